// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider returning {remainder, quotient}.
// Define DIV_ZERO_FAST_EN to short-circuit a zero divisor in one edge.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

`ifdef DIV_ZERO_FAST_EN
    localparam logic ZERO_FAST = 1'b1;
`else
    localparam logic ZERO_FAST = 1'b0;
`endif

    typedef enum logic [1:0] {
        DIV_FREE,
        DIV_BY_ZERO,
        DIV_ON,
        DIV_END
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [32:0] tmp;
    logic [31:0] op1_abs;
    logic [31:0] op2_abs;
    logic [31:0] quot;
    logic [31:0] rem;

    assign result_o = result_q;
    assign ready_o  = ready_q;

    // Magnitudes wrap 0x80000000 onto itself, which reads as unsigned 2^31.
    assign op1_abs = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
    assign tmp     = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
    assign quot    = negq_q ? -dividend_q[31:0] : dividend_q[31:0];
    assign rem     = negr_q ? -dividend_q[64:33] : dividend_q[64:33];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        result_d   = result_q;
        ready_d    = ready_q;
        unique case (state_q)
            DIV_FREE: begin
                result_d = 64'd0;
                ready_d  = 1'b0;
                if (start_i == DIV_START && !annul_i) begin
                    if (ZERO_FAST && opdata2_i == 32'd0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        divisor_d  = op2_abs;
                        dividend_d = {32'd0, op1_abs, 1'b0};
                        negq_d     = signed_div_i &
                                     (opdata1_i[31] ^ opdata2_i[31]);
                        negr_d     = signed_div_i & opdata1_i[31];
                        cnt_d      = 6'd0;
                        state_d    = DIV_ON;
                    end
                end
            end
            DIV_BY_ZERO: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                    cnt_d   = 6'd0;
                end else begin
                    dividend_d = 65'd0;
                    result_d   = 64'd0;
                    ready_d    = 1'b1;
                    state_d    = DIV_END;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                    cnt_d   = 6'd0;
                end else if (cnt_q != 6'd32) begin
                    if (tmp[32]) begin
                        dividend_d = {dividend_q[63:0], 1'b0};
                    end else begin
                        dividend_d = {tmp[31:0], dividend_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {rem, quot};
                    ready_d  = 1'b1;
                    cnt_d    = 6'd0;
                    state_d  = DIV_END;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                    state_d  = DIV_FREE;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= 6'd0;
            dividend_q <= 65'd0;
            divisor_q  <= 32'd0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            negq_q     <= negq_d;
            negr_q     <= negr_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomized scoreboard bench for div_unit against an arithmetic model.
// Honours DIV_ZERO_FAST_EN the same way the design build does.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = 32'd0;
    logic [31:0] opdata2_i = 32'd0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    div_unit dut (
        .clk(clk),
        .rst(rst),
        .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i),
        .opdata2_i(opdata2_i),
        .start_i(start_i),
        .annul_i(annul_i),
        .result_o(result_o),
        .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          issue;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    logic rdy_prev = 1'b0;

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    always @(posedge clk) cyc++;

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, req);
    endtask

    function automatic logic [63:0] ref_div(input logic s,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint unsigned ma, mb, q, r;
        ma = (s && a[31]) ? (64'd4294967296 - a) : 64'(a);
        mb = (s && b[31]) ? (64'd4294967296 - b) : 64'(b);
        if (b == 0) begin
            if (FAST) return 64'd0;
            q = 64'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (s && (a[31] ^ b[31])) q = 64'd4294967296 - q;
        if (s && a[31]) r = 64'd4294967296 - r;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: every rising ready_o must match the oldest expectation.
    always @(negedge clk) begin
        if (ready_o && !rdy_prev) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_ready", result_o, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk(result_o == e.res, "result", result_o, e.res);
                chk(cyc - e.issue - 1 == e.lat, "latency",
                    64'(cyc - e.issue - 1), 64'(e.lat));
            end
        end
        rdy_prev = ready_o;
    end

    task automatic run_div(input logic s, input logic [31:0] a,
                           input logic [31:0] b, input int hold);
        exp_t e;
        int   n;
        @(negedge clk);
        signed_div_i = s;
        opdata1_i = a;
        opdata2_i = b;
        start_i = 1'b1;
        e.res = ref_div(s, a, b);
        e.lat = (FAST && b == 0) ? 1 : 33;
        e.issue = cyc;
        exp_q.push_back(e);
        n = 0;
        while (!ready_o && n < 100) begin
            @(negedge clk);
            if (n == 0) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                signed_div_i = $urandom_range(0, 1);
            end
            n++;
        end
        if (!ready_o) begin
            chk(1'b0, "ready_timeout", 64'(ready_o), 64'd1);
            void'(exp_q.pop_front());
        end
        repeat (hold) begin
            @(negedge clk);
            chk(ready_o && result_o == e.res, "hold",
                result_o, e.res);
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk(!ready_o && result_o == 64'd0, "release",
            {result_o[62:0], ready_o}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        int k;
        #1;
        chk(!ready_o && result_o == 64'd0, "reset",
            result_o, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, 5);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        run_div(1'b0, 32'h1234, 32'd0, 0);
        run_div(1'b1, 32'h8000_1234, 32'd0, 0);

        // Annul at iteration 10: nothing may come back.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i = 32'hFFFF_FFFF;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        k = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) k++;
        end
        chk(k == 0, "annul_quiet", 64'(k), 64'd0);
        run_div(1'b0, 32'd9, 32'd3, 0);

        // Async reset mid-DivOn, then while a result is held.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd9;
        start_i = 1'b1;
        repeat (15) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk(!ready_o && result_o == 64'd0, "rst_mid_on",
            result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst = 1'b1;
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i = 32'd55;
        opdata2_i = 32'd5;
        start_i = 1'b1;
        begin
            exp_t e;
            e.res = ref_div(1'b0, 32'd55, 32'd5);
            e.lat = 33;
            e.issue = cyc;
            exp_q.push_back(e);
        end
        repeat (36) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk(!ready_o && result_o == 64'd0, "rst_in_end",
            result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 17));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_div(1'($urandom_range(0, 1)), a, b, 0);
        end

        repeat (3) @(negedge clk);
        chk(exp_q.size() == 0, "queue_empty",
            64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle radix-2 restoring divider for the OpenMIPS datapath. It sits directly downstream of the execute stage. It accepts DIV/DIVU operands and a start request from EX while EX stalls the pipeline. It returns a 64-bit {remainder, quotient} result with a ready flag, which EX writes into HI/LO.

## Interface
- No parameters; widths come from `defines.v` (`RegBus` = 32, `DoubleRegBus` = 64).
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- signed_div_i  input  1  1 = signed DIV, 0 = unsigned DIVU.
- opdata1_i  input  32  dividend.
- opdata2_i  input  32  divisor.
- start_i  input  1  `DivStart` requests a divide; `DivStop` releases the result.
- annul_i  input  1  1 = abort the current or pending divide (flush or exception).
- result_o  output  64  [63:32] remainder (to HI), [31:0] quotient (to LO).
- ready_o  output  1  `DivResultReady` when result_o is valid.

## Operation
- The FSM has four states: DivFree, DivByZero, DivOn, DivEnd. The reset state is DivFree.
- Reset (rst = 0, asynchronous, any state):
  - state → DivFree, cnt → 0.
  - result_o = 0, ready_o = `DivResultNotReady`.
- DivFree:
  - Accepts a divide when start_i = `DivStart` and annul_i = 0.
  - If the divisor is 0 and `DIV_ZERO_FAST_EN` is defined → DivByZero.
  - Otherwise:
    - Latch operands into internal registers. For a signed divide with a negative operand, latch its two's complement magnitude; 0x80000000 is kept as unsigned 2^31.
    - Load dividend register (65 b) = {32'b0, |op1|, 1'b0}. Set cnt = 0. Go to DivOn.
  - ready_o = 0, result_o = 0.
- DivByZero: dividend register = 0, go to DivEnd on the next edge.
- DivOn, one iteration per edge while cnt < 32:
  - tmp = {1'b0, dividend[63:32]} − {1'b0, divisor}.
  - If tmp[32] = 1: dividend ← {dividend[63:0], 1'b0}.
  - Else: dividend ← {tmp[31:0], dividend[31:0], 1'b1}.
  - cnt ← cnt + 1.
- DivOn, edge with cnt == 32:
  - quotient = dividend[31:0]; remainder = dividend[64:33].
  - For a signed divide with op1[31] ^ op2[31], negate the quotient.
  - For a signed divide with op1[31], negate the remainder.
  - Register result_o, set ready_o = 1, go to DivEnd.
- DivEnd:
  - Hold result_o and ready_o.
  - When start_i = `DivStop`: next edge → DivFree, ready_o = 0, result_o = 0.
- annul_i = 1 in DivOn or DivByZero: next edge → DivFree, cnt = 0, ready_o stays 0, no result produced.
- annul_i in DivEnd has no effect; the release is governed by start_i only.
- Operand changes after acceptance are ignored because the operands are latched.

## Timing
- Acceptance edge = E0.
- Normal path: iterations on E1–E32, finalisation on E33. ready_o is high from E33 until the edge after start_i drops.
- Divide-by-zero fast path: DivByZero on E0, DivEnd on E1, ready_o high from E1.
- A new divide can be accepted no earlier than the edge after the return to DivFree. Minimum back-to-back spacing is 35 edges.
- ready_o and result_o are registered, with no combinational path from the inputs.
- EX holds start_i = `DivStart` through DivOn and drops it in the cycle it sees ready_o = 1.

## Configuration
- `DIV_ZERO_FAST_EN` defined:
  - divisor == 0 takes the DivByZero path.
  - result_o = 0 on both halves; latency is 1 edge.
- `DIV_ZERO_FAST_EN` undefined:
  - No special case; divisor 0 runs the full 32 iterations.
  - Unsigned result: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed result: the same values after the sign rules above.
  - Latency is 33 edges.

## Test plan
- Unsigned 100 / 7: ready_o rises after E33; result_o = {0x00000002, 0x0000000E}.
- Signed −7 / 2: result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Signed 7 / −2: result_o = {0x00000001, 0xFFFFFFFD}.
- Unsigned 0x1234 / 0:
  - With `DIV_ZERO_FAST_EN`: ready_o after E1, result_o = 0.
  - Without it: ready_o after E33, result_o = {0x00001234, 0xFFFFFFFF}.
- annul_i pulsed at iteration 10 of 0xFFFFFFFF / 3:
  - ready_o never rises; FSM is in DivFree next cycle.
  - A following 9 / 3 returns {0, 3}.
- Hold start_i for 5 cycles after ready_o rises: result_o is stable and ready_o stays 1. Then drop start_i: ready_o = 0 and result_o = 0 on the next edge.
- Assert rst low asynchronously mid-DivOn, between edges: outputs clear immediately. After release, 0x80000000 / 0xFFFFFFFF (signed) returns {0, 0x80000000}.
